// File: rtl/mandelbrot_streamer.sv
// Streams one Mandelbrot frame as 32-bit {R,G,B,0} AXI4-Stream pixels.
// Each pixel runs a fixed-point z <= z^2 + c escape loop, one iteration per cycle.
module mandelbrot_streamer #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480,
    parameter int W      = 32,
    parameter int FRAC   = 24
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                enable,
    input  logic signed [W-1:0] cfg_x0,
    input  logic signed [W-1:0] cfg_y0,
    input  logic        [W-1:0] cfg_step,
    input  logic        [7:0]   cfg_max_iter,
    output logic        [31:0]  out_stream_tdata,
    output logic        [3:0]   out_stream_tkeep,
    output logic                out_stream_tlast,
    output logic                out_stream_tuser,
    output logic                out_stream_tvalid,
    input  logic                out_stream_tready,
    output logic                frame_done
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int W1 = W + 1;
    localparam int W2 = 2 * W;
    localparam logic signed [W:0] FOUR = W1'(4) <<< FRAC;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, OUT} state_t;

    state_t               state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [7:0]           iter_q, iter_d;
    logic signed [W-1:0]  zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic signed [W-1:0]  x0_q, x0_d, y0_q, y0_d;
    logic [W-1:0]         step_q, step_d;
    logic [7:0]           max_iter_q, max_iter_d;
    logic [31:0]          tdata_q, tdata_d;
    logic                 tuser_q, tuser_d, tlast_q, tlast_d;
    logic                 frame_done_q, frame_done_d;

    logic signed [W2-1:0] prod_rr, prod_ii, prod_ri;
    logic signed [W-1:0]  zr2, zi2;
    logic signed [W:0]    mag;
    logic                 x_last, y_last, first_pix, last_pix;
    logic                 unused_prod_bits;

    // Squares keep bits [FRAC +: W]; the cross term takes one bit lower to fold in the factor 2.
    assign prod_rr = W2'(zr_q) * W2'(zr_q);
    assign prod_ii = W2'(zi_q) * W2'(zi_q);
    assign prod_ri = W2'(zr_q) * W2'(zi_q);
    assign zr2     = prod_rr[FRAC +: W];
    assign zi2     = prod_ii[FRAC +: W];
    assign mag     = W1'(zr2) + W1'(zi2);
    assign unused_prod_bits = ^{prod_rr, prod_ii, prod_ri};

    assign x_last    = (x_q == XW'(X_SIZE - 1));
    assign y_last    = (y_q == YW'(Y_SIZE - 1));
    assign first_pix = (x_q == '0) && (y_q == '0);
    assign last_pix  = x_last && y_last;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        iter_d       = iter_q;
        zr_d         = zr_q;
        zi_d         = zi_q;
        cr_d         = cr_q;
        ci_d         = ci_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        step_d       = step_q;
        max_iter_d   = max_iter_q;
        tdata_d      = tdata_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && first_pix) begin
                    x0_d       = cfg_x0;
                    y0_d       = cfg_y0;
                    step_d     = cfg_step;
                    max_iter_d = cfg_max_iter;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cr_d    = x0_q + W'(x_q) * step_q;
                ci_d    = y0_q + W'(y_q) * step_q;
                zr_d    = '0;
                zi_d    = '0;
                iter_d  = '0;
                state_d = ITER;
            end
            ITER: begin
                if (mag > FOUR) begin
                    tdata_d = {iter_q, iter_q, iter_q, 8'h00};
                    tuser_d = first_pix;
                    tlast_d = last_pix;
                    state_d = OUT;
                end else if (iter_q == max_iter_q) begin
                    tdata_d = '0;
                    tuser_d = first_pix;
                    tlast_d = last_pix;
                    state_d = OUT;
                end else begin
                    zi_d   = prod_ri[FRAC-1 +: W] + ci_q;
                    zr_d   = zr2 - zi2 + cr_q;
                    iter_d = iter_q + 8'd1;
                end
            end
            OUT: begin
                if (out_stream_tready) begin
                    if (last_pix) begin
                        x_d          = '0;
                        y_d          = '0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        if (x_last) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            iter_q       <= '0;
            zr_q         <= '0;
            zi_q         <= '0;
            cr_q         <= '0;
            ci_q         <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            step_q       <= '0;
            max_iter_q   <= '0;
            tdata_q      <= '0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            iter_q       <= iter_d;
            zr_q         <= zr_d;
            zi_q         <= zi_d;
            cr_q         <= cr_d;
            ci_q         <= ci_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            step_q       <= step_d;
            max_iter_q   <= max_iter_d;
            tdata_q      <= tdata_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = 4'b1111;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tvalid = (state_q == OUT);
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_mandelbrot_streamer.sv
// Self-checking bench for mandelbrot_streamer on a 4x2 frame with Q8.24 coordinates.
// A floating-free escape-time model predicts every beat; a monitor compares each valid cycle.
module tb_mandelbrot_streamer;

    localparam int XS   = 4;
    localparam int YS   = 2;
    localparam int NPIX = XS * YS;
    localparam int ONE  = 32'h0100_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] cfg_x0 = '0, cfg_y0 = '0, cfg_step = '0;
    logic [7:0]  cfg_max_iter = '0;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
    logic        out_stream_tready = 1'b0;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_data [NPIX];

    mandelbrot_streamer #(.X_SIZE(XS), .Y_SIZE(YS), .W(32), .FRAC(24)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_step(cfg_step), .cfg_max_iter(cfg_max_iter),
        .out_stream_tdata(out_stream_tdata), .out_stream_tkeep(out_stream_tkeep),
        .out_stream_tlast(out_stream_tlast), .out_stream_tuser(out_stream_tuser),
        .out_stream_tvalid(out_stream_tvalid), .out_stream_tready(out_stream_tready),
        .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Escape-time reference: Q8.24 arithmetic, squares floored then truncated to 32 bits.
    function automatic void model(input int x0, input int y0, input int step, input int maxit,
                                  input int px, input int py,
                                  output logic [31:0] data, output int cycles);
        int cr, ci, zr, zi, zr2, zi2, zin;
        logic [7:0] c8;
        cr = x0 + px * step;
        ci = y0 + py * step;
        zr = 0;
        zi = 0;
        data = '0;
        cycles = 0;
        for (int it = 0; it <= maxit; it++) begin
            zr2 = int'((longint'(zr) * longint'(zr)) >>> 24);
            zi2 = int'((longint'(zi) * longint'(zi)) >>> 24);
            if (longint'(zr2) + longint'(zi2) > (longint'(4) <<< 24)) begin
                c8 = it[7:0];
                data = {c8, c8, c8, 8'h00};
                cycles = it + 1;
                return;
            end
            if (it == maxit) begin
                data = '0;
                cycles = it + 1;
                return;
            end
            zin = int'((longint'(zr) * longint'(zi) * 2) >>> 24);
            zr  = zr2 - zi2 + cr;
            zi  = zin + ci;
        end
    endfunction

    task automatic prep(input int x0, input int y0, input int step, input int maxit);
        int cyc;
        cfg_x0 = x0;
        cfg_y0 = y0;
        cfg_step = step;
        cfg_max_iter = maxit[7:0];
        for (int p = 0; p < NPIX; p++)
            model(x0, y0, step, maxit, p % XS, p / XS, exp_data[p], cyc);
    endtask

    // Monitor: every cycle checks frame_done; on valid cycles checks the beat against the model.
    int idx = 0;
    bit pend = 0;
    always @(negedge aclk) begin
        if (!aresetn) begin
            idx = 0;
            pend = 0;
            chk("rst_tvalid", 64'(out_stream_tvalid), 64'd0);
            chk("rst_frame_done", 64'(frame_done), 64'd0);
            chk("rst_tkeep", 64'(out_stream_tkeep), 64'hf);
        end else begin
            chk("frame_done", 64'(frame_done), 64'(pend));
            pend = 0;
            if (out_stream_tvalid) begin
                chk($sformatf("tdata[%0d]", idx), 64'(out_stream_tdata), 64'(exp_data[idx]));
                chk($sformatf("tuser[%0d]", idx), 64'(out_stream_tuser), 64'(idx == 0));
                chk($sformatf("tlast[%0d]", idx), 64'(out_stream_tlast), 64'(idx == NPIX - 1));
                chk("tkeep", 64'(out_stream_tkeep), 64'hf);
                if (out_stream_tready) begin
                    pend = (idx == NPIX - 1);
                    idx = (idx == NPIX - 1) ? 0 : idx + 1;
                end
            end
        end
    end

    // Counts cycles from the LOAD cycle (1) to the first cycle with tvalid.
    task automatic wait_tvalid(output int cnt);
        cnt = 0;
        while (cnt < 3000) begin
            @(negedge aclk);
            cnt++;
            if (out_stream_tvalid) break;
        end
        if (!out_stream_tvalid) chk("tvalid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 5000 && !frame_done) begin
            @(negedge aclk);
            n++;
        end
        chk("frame_done_seen", 64'(frame_done), 64'd1);
    endtask

    task automatic idle_check(input string name, input int n);
        bit seen = 0;
        repeat (n) begin
            @(negedge aclk);
            if (out_stream_tvalid) seen = 1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [34:0] snap;
        int c, cnt;

        // Hand-computed pins for the model.
        model(ONE, 0, 0, 255, 0, 0, d, c);
        chk("pin_c1_data", 64'(d), 64'h0303_0300);
        chk("pin_c1_cycles", 64'(c), 64'd4);
        model(-2 * ONE, 0, 0, 255, 0, 0, d, c);
        chk("pin_cm2_data", 64'(d), 64'd0);
        chk("pin_cm2_cycles", 64'(c), 64'd256);
        model(3 * ONE, 0, 0, 255, 0, 0, d, c);
        chk("pin_c3_data", 64'(d), 64'h0101_0100);
        model(ONE, 0, 0, 0, 0, 0, d, c);
        chk("pin_max0_cycles", 64'(c), 64'd1);

        repeat (3) @(posedge aclk);
        #1;
        chk("reset_tdata", 64'(out_stream_tdata), 64'd0);
        chk("reset_tuser_tlast", 64'({out_stream_tuser, out_stream_tlast}), 64'd0);
        aresetn = 1'b1;
        idle_check("idle_no_enable", 20);

        // Frame 1: c from 1.0 step 0.25; enable and config disturbed mid-frame.
        prep(ONE, 0, ONE / 4, 255);
        @(posedge aclk); #1;
        out_stream_tready = 1'b1;
        enable = 1'b1;
        @(posedge aclk);
        wait_tvalid(cnt);
        enable = 1'b0;
        cfg_x0 = 32'h8000_0000;
        cfg_step = 32'h0070_0000;
        cfg_max_iter = 8'd3;
        chk("f1_latency", 64'(cnt), 64'd6);
        chk("f1_first_tdata", 64'(out_stream_tdata), 64'h0303_0300);
        chk("f1_first_tuser", 64'(out_stream_tuser), 64'd1);
        wait_done();
        idle_check("f1_back_to_idle", 20);

        // Frame 2: in-set first pixel at the |z|^2==4 boundary, with a 10-cycle stall.
        prep(-2 * ONE, 0, ONE / 2, 255);
        @(posedge aclk); #1;
        out_stream_tready = 1'b0;
        enable = 1'b1;
        @(posedge aclk);
        wait_tvalid(cnt);
        enable = 1'b0;
        chk("f2_latency", 64'(cnt), 64'd258);
        chk("f2_first_tdata", 64'(out_stream_tdata), 64'd0);
        snap = {out_stream_tuser, out_stream_tlast, out_stream_tvalid, out_stream_tdata};
        repeat (10) begin
            @(negedge aclk);
            chk("stall_hold", 64'({out_stream_tuser, out_stream_tlast, out_stream_tvalid, out_stream_tdata}),
                64'(snap));
        end
        @(posedge aclk); #1;
        out_stream_tready = 1'b1;
        wait_done();

        // Frame 3: max_iter 0 gives black pixels, one ITER cycle each.
        prep(ONE, 0, ONE / 4, 0);
        @(posedge aclk); #1;
        enable = 1'b1;
        @(posedge aclk);
        wait_tvalid(cnt);
        enable = 1'b0;
        chk("f3_latency", 64'(cnt), 64'd3);
        wait_done();

        // Reset while a beat is presented and stalled.
        prep(-2 * ONE, 0, ONE / 2, 255);
        @(posedge aclk); #1;
        out_stream_tready = 1'b0;
        enable = 1'b1;
        @(posedge aclk);
        wait_tvalid(cnt);
        enable = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        chk("async_rst_tvalid", 64'(out_stream_tvalid), 64'd0);
        chk("async_rst_tdata", 64'(out_stream_tdata), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Reset mid-ITER, then a fresh frame must start at pixel (0,0).
        @(posedge aclk); #1;
        enable = 1'b1;
        repeat (30) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("iter_rst_tvalid", 64'(out_stream_tvalid), 64'd0);
        enable = 1'b0;
        prep(ONE, 0, ONE / 4, 255);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        out_stream_tready = 1'b1;
        enable = 1'b1;
        @(posedge aclk);
        wait_tvalid(cnt);
        enable = 1'b0;
        chk("f5_latency", 64'(cnt), 64'd6);
        chk("f5_first_tuser", 64'(out_stream_tuser), 64'd1);
        chk("f5_first_tdata", 64'(out_stream_tdata), 64'h0303_0300);
        wait_done();
        idle_check("f5_back_to_idle", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mandelbrot_streamer.md
MANDELBROT_STREAMER -- requirements
Module: mandelbrot_streamer

Interface
REQ-001 SHALL have parameter X_SIZE, default 640, pixels per line.
REQ-002 SHALL have parameter Y_SIZE, default 480, lines per frame.
REQ-003 SHALL have parameter W, default 32, signed fixed-point width of all complex-plane values.
REQ-004 SHALL have parameter FRAC, default 24, fractional bits; W-FRAC >= 8 required.
REQ-005 SHALL have port aclk, input, 1, single clock; all logic rising-edge.
REQ-006 SHALL have port aresetn, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1, permits start of a new frame.
REQ-008 SHALL have port cfg_x0, input, W, signed real coordinate of pixel x=0.
REQ-009 SHALL have port cfg_y0, input, W, signed imaginary coordinate of line y=0.
REQ-010 SHALL have port cfg_step, input, W, unsigned per-pixel step, same on both axes.
REQ-011 SHALL have port cfg_max_iter, input, 8, iteration limit.
REQ-012 SHALL have port out_stream_tdata, output, 32, {R,G,B,8'h00}.
REQ-013 SHALL have port out_stream_tkeep, output, 4, constant 4'b1111.
REQ-014 SHALL have port out_stream_tlast, output, 1, last pixel of frame.
REQ-015 SHALL have port out_stream_tuser, output, 1, first pixel of frame.
REQ-016 SHALL have ports out_stream_tvalid (output, 1) and out_stream_tready (input, 1), AXI4-Stream handshake.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse after the tlast beat is accepted.

Function
REQ-018 SHALL use FSM states IDLE, LOAD, ITER, OUT.
REQ-019 IDLE SHALL go to LOAD when enable=1 and x=y=0; at that transition cfg_x0, cfg_y0, cfg_step, cfg_max_iter SHALL be latched and held for the whole frame.
REQ-020 LOAD (1 cycle) SHALL set cr = x0 + x*step and ci = y0 + y*step, zr = zi = 0, iter = 0, then go to ITER.
REQ-021 Each ITER cycle SHALL compute zr2 = zr*zr and zi2 = zi*zi at 2W, then shift right by FRAC and truncate to W.
REQ-022 In an ITER cycle, if zr2+zi2 > 4.0 (4<<FRAC, strict), the pixel SHALL escape with count iter and the FSM SHALL go to OUT.
REQ-023 Otherwise, if iter == max_iter, the pixel SHALL be in-set and the FSM SHALL go to OUT.
REQ-024 Otherwise the ITER cycle SHALL update zi <= 2*zr*zi + ci and zr <= zr2 - zi2 + cr, and iter SHALL increment.
REQ-025 Latency per pixel SHALL be 1 LOAD cycle plus (n+1) ITER cycles, where n = iterations performed, plus OUT residency.
REQ-026 tdata SHALL be registered on OUT entry: an escape with count i SHALL give {i,i,i,8'h00}; an in-set pixel SHALL give 32'h0.
REQ-027 tvalid SHALL be 1 only in OUT; tdata, tuser, and tlast SHALL be stable while tvalid=1 and tready=0.
REQ-028 tuser SHALL be 1 only on the beat with x=0, y=0; tlast SHALL be 1 only on the beat with x=X_SIZE-1, y=Y_SIZE-1.
REQ-029 On tvalid&tready, x SHALL increment; at x=X_SIZE-1, x SHALL wrap to 0 and y SHALL increment; at the last pixel, y SHALL wrap to 0.
REQ-030 After a non-last beat the FSM SHALL go to LOAD; after the last beat it SHALL go to IDLE and pulse frame_done.
REQ-031 Deasserting enable mid-frame SHALL NOT stop the frame; it only blocks the next frame start.
REQ-032 cfg_max_iter = 0 SHALL make every pixel in-set (black), with one ITER cycle per pixel.
REQ-033 Config changes mid-frame SHALL be ignored until the next IDLE->LOAD transition.

Reset
REQ-034 aresetn=0 SHALL asynchronously force state=IDLE, x=0, y=0, iter=0, and zr=zi=cr=ci=0.
REQ-035 aresetn=0 SHALL asynchronously force tvalid=0, tdata=0, tuser=0, tlast=0, frame_done=0; tkeep SHALL remain 4'b1111.
REQ-036 Reset asserted mid-pixel or mid-frame SHALL abandon the frame; the next frame SHALL restart at x=y=0 with tuser=1.

Verification
REQ-037 Reset -> tvalid=0 and frame_done=0; with enable=0 held after release, tvalid SHALL stay 0 indefinitely.
REQ-038 x0=1.0, y0=0, max_iter=255, tready=1 -> first beat tdata=32'h03030300 and tuser=1, appearing 6 cycles after leaving IDLE.
REQ-039 x0=-2.0, y0=0, max_iter=255 -> first pixel is in-set with tdata=32'h0 (|z|^2=4 is not >4) after 256 ITER cycles.
REQ-040 X_SIZE=4, Y_SIZE=2, tready=1 -> exactly 8 beats; tuser on beat 1 only, tlast on beat 8 only, frame_done one cycle later, then back to IDLE.
REQ-041 tready held 0 for 10 cycles during OUT -> tvalid stays 1 and tdata/tuser/tlast are unchanged; x advances only on the accepting edge.
REQ-042 aresetn pulsed low mid-ITER -> tvalid drops immediately; after release with enable=1, the first beat has tuser=1 and uses x=y=0.
